ps2_keyboard_interface: RTL and testbench

- Receive-only PS/2 keyboard port.
- Deserialises 11-bit device-to-host frames from the ps2_clock/ps2_data lines into bytes and pulses a strobe per valid byte.
- Holds the last byte for display paths (LCD, seven-segment).
- Sits between the board PS/2 pins and the top-level skeleton; it never drives the bus.

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_edge_filter.sv | 45 ++++
 rtl/ps2_keyboard_interface.sv | 120 ++++++++++++
 tb/tb_ps2_keyboard_interface.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/ps2_edge_filter.sv
// Two-flop synchroniser plus stability filter for the PS/2 clock line;
// emits a one-cycle pulse when the filtered level falls from 1 to 0.
module ps2_edge_filter #(
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic line,
    output logic fall
);

    localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        fall    = 1'b0;
        // Any sample that agrees with the current level restarts the run.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                level_d = sync_q[1];
                fall    = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], line};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_keyboard_interface.sv
// Receive-only PS/2 keyboard port: deserialises device-to-host frames into
// bytes, strobes once per valid byte and holds the last byte for display.
module ps2_keyboard_interface
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire        ps2_clock,
    inout  wire        ps2_data,
    output logic [7:0] ps2_key_data,
    output logic       ps2_key_pressed,
    output logic [7:0] ps2_out
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    // The host never drives the bus.
    assign ps2_clock = 1'bz;
    assign ps2_data  = 1'bz;

    logic       fall;
    logic [1:0] data_sync_q;
    logic       data_s;

    ps2_edge_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_clock_filter (
        .clock(clock),
        .reset(reset),
        .line (ps2_clock),
        .fall (fall)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) data_sync_q <= 2'b11;
        else       data_sync_q <= {data_sync_q[0], ps2_data};
    end
    assign data_s = data_sync_q[1];

    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic          timeout_hit;
    logic          commit;
    logic [7:0]    key_q;
    logic          pressed_q;

    assign timeout_hit = (state_q != StIdle) && (timeout_q == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        commit    = 1'b0;
        if (fall || state_q == StIdle || timeout_hit) timeout_d = '0;
        else                                         timeout_d = timeout_q + 1'b1;

        if (timeout_hit) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
        end else if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (data_s == START_BIT) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d   = StParity;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    parity_d = data_s;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    commit  = (data_s == STOP_BIT) && (^{shift_q, parity_q});
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            timeout_q <= '0;
            key_q     <= '0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            timeout_q <= timeout_d;
            pressed_q <= commit;
            if (commit) key_q <= shift_q;
        end
    end

    assign ps2_key_data    = key_q;
    assign ps2_out         = key_q;
    assign ps2_key_pressed = pressed_q;

endmodule

// File: tb/tb_ps2_keyboard_interface.sv
// Scoreboarded bench: frames are generated from bytes, the acceptance rule
// decides what gets queued, and a monitor checks every strobe it sees.
module tb_ps2_keyboard_interface;

    localparam int unsigned FILT = 8;
    localparam int unsigned TMO  = 400;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic clk_drv = 1'b1;
    logic dat_drv = 1'b1;
    wire  ps2_clock_w;
    wire  ps2_data_w;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic [7:0] ps2_out;

    assign ps2_clock_w = clk_drv;
    assign ps2_data_w  = dat_drv;

    ps2_keyboard_interface #(
        .FILTER_CYCLES (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ps2_clock      (ps2_clock_w),
        .ps2_data       (ps2_data_w),
        .ps2_key_data   (ps2_key_data),
        .ps2_key_pressed(ps2_key_pressed),
        .ps2_out        (ps2_out)
    );

    always #10 clock = ~clock;

    logic [7:0] exp_q[$];
    logic [7:0] last_byte = 8'h00;
    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int exp_strobes = 0;

    always @(negedge clock) begin
        if (ps2_key_pressed) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe data got %02h, no byte expected", ps2_key_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (ps2_key_data !== e || ps2_out !== e) begin
                    errors++;
                    $display("FAIL strobe_byte key_data %02h ps2_out %02h expected %02h",
                             ps2_key_data, ps2_out, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits, input int h);
        for (int i = 0; i < nbits; i++) begin
            dat_drv = f[i];
            wait_cyc(h);
            clk_drv = 1'b0;
            wait_cyc(h);
            clk_drv = 1'b1;
        end
        dat_drv = 1'b1;
    endtask

    // Reference rule: a complete frame yields its byte iff stop is 1 and parity is odd.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int h);
        if (!bad_par && !bad_stop) begin
            exp_q.push_back(b);
            last_byte = b;
            exp_strobes++;
        end
        send_bits(mk_frame(b, bad_par, bad_stop), 11, h);
    endtask

    task automatic settle_and_check(input string name);
        wait_cyc(FILT + 20);
        check({name, "_strobes"}, strobes, exp_strobes);
        check({name, "_out"}, ps2_out, last_byte);
        check({name, "_key"}, ps2_key_data, last_byte);
    endtask

    initial begin
        wait_cyc(5);
        check("reset_key_data", ps2_key_data, 8'h00);
        check("reset_out", ps2_out, 8'h00);
        check("reset_pressed", ps2_key_pressed, 1'b0);
        reset = 1'b0;
        wait_cyc(20);

        send_frame(8'h1C, 0, 0, 40);
        settle_and_check("clean_1c");

        send_frame(8'hF0, 0, 0, 40);
        send_frame(8'h1C, 0, 0, 40);
        settle_and_check("break_seq");

        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        last_byte = 8'h00;
        wait_cyc(10);
        send_frame(8'h1C, 1, 0, 40);
        settle_and_check("bad_parity");

        send_bits(mk_frame(8'h33, 0, 0), 5, 40);
        wait_cyc(TMO + 200);
        send_frame(8'h5A, 0, 0, 40);
        settle_and_check("timeout");

        clk_drv = 1'b0;
        wait_cyc(2);
        clk_drv = 1'b1;
        wait_cyc(60);
        check("glitch_strobes", strobes, exp_strobes);
        send_frame(8'h6B, 0, 0, 40);
        settle_and_check("after_glitch");

        send_bits(mk_frame(8'h77, 0, 0), 4, 40);
        reset = 1'b1;
        #1;
        check("midreset_key", ps2_key_data, 8'h00);
        check("midreset_out", ps2_out, 8'h00);
        check("midreset_pressed", ps2_key_pressed, 1'b0);
        last_byte = 8'h00;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(10);
        send_frame(8'h29, 0, 0, 40);
        settle_and_check("after_reset");

        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            int err;
            int h;
            b = 8'($urandom);
            err = $urandom_range(0, 9);
            h = $urandom_range(25, 50);
            send_frame(b, err == 0, err == 1, h);
            if ($urandom_range(0, 2) != 0) wait_cyc($urandom_range(1, 100));
        end
        settle_and_check("random");
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
